// File: rtl/dff_arb_pkg.sv
// Shared types and constants for the shared-register arbiter slice.
package dff_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int N_DEF   = 4;
    localparam int OWNER_W = $clog2(N_DEF);
    localparam int CNT_W   = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int OW = OWNER_W
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] last,
    output logic          valid,
    output logic [OW-1:0] idx
);

    int pos_s;

    // Scan from farthest to nearest so the nearest set bit after 'last' wins.
    always_comb begin
        valid = |req;
        idx   = {OW{1'b0}};
        pos_s = 0;
        for (int k = N; k >= 1; k--) begin
            pos_s = (int'(last) + k) % N;
            if (req[pos_s]) begin
                idx = OW'(pos_s);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit register bank between N requesters,
// allowing up to HOLD_MAX consecutive writes per grant.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int W        = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        wdata,
    output logic [N-1:0]          grant,
    output logic [$clog2(N)-1:0]  owner,
    output logic                  wr_ack,
    output logic [W-1:0]          q,
    output logic [W-1:0]          qb
);

    localparam int OW = $clog2(N);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("dff_bank_arbiter: N must be in 2..8");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold
        $error("dff_bank_arbiter: HOLD_MAX must be in 1..15");
    end

    state_t            state_r;
    logic [N-1:0]      grant_r;
    logic [OW-1:0]     owner_r;
    logic [OW-1:0]     last_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              wr_ack_r;
    logic [W-1:0]      q_r;
    logic              pick_valid_s;
    logic [OW-1:0]     pick_idx_s;

    rr_pick #(
        .N  (N),
        .OW (OW)
    ) u_pick (
        .req   (req),
        .last  (last_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Grant/write sequencer and the shared register bank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            grant_r  <= {N{1'b0}};
            owner_r  <= {OW{1'b0}};
            last_r   <= OW'(N - 1);
            cnt_r    <= {CNT_W{1'b0}};
            wr_ack_r <= 1'b0;
            q_r      <= {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wr_ack_r <= 1'b0;
                    if (pick_valid_s) begin
                        grant_r <= {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
                        owner_r <= pick_idx_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_GRANT;
                    end else begin
                        grant_r <= {N{1'b0}};
                    end
                end
                ST_GRANT: begin
                    if (req[owner_r]) begin
                        q_r      <= wdata[int'(owner_r)*W +: W];
                        wr_ack_r <= 1'b1;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        // Last allowed write of this grant: release after it lands.
                        if (cnt_r == CNT_W'(HOLD_MAX - 1)) begin
                            grant_r <= {N{1'b0}};
                            last_r  <= owner_r;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_GRANT;
                        end
                    end else begin
                        wr_ack_r <= 1'b0;
                        grant_r  <= {N{1'b0}};
                        last_r   <= owner_r;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    grant_r  <= {N{1'b0}};
                    wr_ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant  = grant_r;
    assign owner  = owner_r;
    assign wr_ack = wr_ack_r;
    assign q      = q_r;
    assign qb     = ~q_r;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Randomised self-checking bench for dff_bank_arbiter against a transaction-level model.
module tb_dff_bank_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int HOLD_MAX = 4;
    localparam int OW       = $clog2(N);
    localparam int VW       = N + OW + 1 + 2*W;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  wdata = '0;
    logic [N-1:0]    grant;
    logic [OW-1:0]   owner;
    logic            wr_ack;
    logic [W-1:0]    q;
    logic [W-1:0]    qb;

    int vectors = 0;
    int miscompares = 0;

    // Model: who holds the register, how many writes it has made, last value.
    bit          m_busy;
    int          m_owner, m_last, m_writes;
    logic [W-1:0] m_q;
    bit          m_ack;

    dff_bank_arbiter #(.N(N), .W(W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .grant(grant), .owner(owner), .wr_ack(wr_ack), .q(q), .qb(qb)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit found;
        if (!rst) begin
            m_busy = 0; m_owner = 0; m_last = N - 1; m_writes = 0; m_q = '0; m_ack = 0;
        end else if (!m_busy) begin
            m_ack = 0;
            if (req != '0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        found = 1;
                    end
                end
                m_busy = 1;
                m_writes = 0;
            end
        end else if (req[m_owner]) begin
            m_q = wdata[m_owner*W +: W];
            m_ack = 1;
            m_writes++;
            if (m_writes == HOLD_MAX) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end else begin
            m_ack = 0;
            m_busy = 0;
            m_last = m_owner;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g;
        g = m_busy ? (N'(1) << m_owner) : '0;
        return {g, OW'(m_owner), m_ack, m_q, ~m_q};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {grant, owner, wr_ack, q, qb};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b1111; wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        tick(); tick();
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant got=%b want=0000", grant); end
        vectors++; if (q !== 8'h00) begin miscompares++; $display("FAIL reset_q got=%h want=00", q); end
        vectors++; if (qb !== 8'hFF) begin miscompares++; $display("FAIL reset_qb got=%h want=ff", qb); end
        vectors++; if (wr_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b want=0", wr_ack); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner got=%0d want=0", owner); end
        rst = 1'b1; req = '0;
        tick();
    endtask

    task automatic test_single();
        int acks = 0;
        req = 4'b0100; wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
        tick();
        vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL single_grant got=%b want=0100", grant); end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (wr_ack === 1'b1) acks++;
            vectors++; if (q !== 8'hA5 || wr_ack !== 1'b1) begin miscompares++; $display("FAIL single_write got q=%h ack=%b want q=a5 ack=1", q, wr_ack); end
        end
        req = '0;
        tick();
        if (wr_ack === 1'b1) acks++;
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL single_release got=%b want=0000", grant); end
        vectors++; if (acks != 2) begin miscompares++; $display("FAIL single_ackcount got=%0d want=2", acks); end
        vectors++; if (act_vec() !== exp_vec()) begin miscompares++; $display("FAIL single_model got=%h want=%h", act_vec(), exp_vec()); end
    endtask

    task automatic test_rotation();
        int owners[$];
        int lens[$];
        int run = 0, gap = 0;
        logic [N-1:0] prev = '0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst = 1'b0; req = '0; tick(); rst = 1'b1;
        req = 4'b1111; wdata = {8'h40, 8'h30, 8'h20, 8'h10};
        for (int c = 0; c < 25; c++) begin
            tick();
            vectors++; if (act_vec() !== exp_vec()) begin miscompares++; $display("FAIL rot_model cyc=%0d got=%h want=%h", c, act_vec(), exp_vec()); end
            if (prev == '0 && grant != '0) begin
                owners.push_back(int'(owner));
                if (owners.size() > 1) begin
                    vectors++; if (gap != 1) begin miscompares++; $display("FAIL rot_gap got=%0d want=1", gap); end
                end
                run = 0;
            end
            if (grant != '0) run++;
            if (prev != '0 && grant == '0) begin lens.push_back(run); gap = 0; end
            if (grant == '0) gap++;
            if (wr_ack) begin
                vectors++; if (q !== W'((int'(owner) + 1) * 16)) begin miscompares++; $display("FAIL rot_data got=%h want=%h", q, W'((int'(owner) + 1) * 16)); end
            end
            prev = grant;
        end
        vectors++; if (owners.size() != 5) begin miscompares++; $display("FAIL rot_count got=%0d want=5", owners.size()); end
        for (int i = 0; i < 5 && i < owners.size(); i++) begin
            vectors++; if (owners[i] != exp_order[i]) begin miscompares++; $display("FAIL rot_order idx=%0d got=%0d want=%0d", i, owners[i], exp_order[i]); end
        end
        foreach (lens[i]) begin
            vectors++; if (lens[i] != HOLD_MAX) begin miscompares++; $display("FAIL rot_len idx=%0d got=%0d want=%0d", i, lens[i], HOLD_MAX); end
        end
        req = '0; tick();
    endtask

    task automatic test_release();
        int acks = 0;
        req = 4'b0010;
        for (int c = 1; c <= 10; c++) begin
            wdata = {$urandom, $urandom};
            tick();
            if (wr_ack) acks++;
            vectors++; if (act_vec() !== exp_vec()) begin miscompares++; $display("FAIL rel_model cyc=%0d got=%h want=%h", c, act_vec(), exp_vec()); end
            if (c == 5) begin
                vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL rel_forced got=%b want=0000", grant); end
            end
            if (c == 6) begin
                vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL rel_regrant got=%b want=0010", grant); end
            end
        end
        vectors++; if (acks != 8) begin miscompares++; $display("FAIL rel_acks got=%0d want=8", acks); end
        tick();
        wdata[1*W +: W] = 8'h5A; tick();
        wdata[1*W +: W] = 8'h6B; tick();
        req = '0; tick();
        vectors++; if (grant !== 4'b0000 || wr_ack !== 1'b0 || q !== 8'h6B) begin miscompares++; $display("FAIL rel_voluntary got g=%b ack=%b q=%h want g=0000 ack=0 q=6b", grant, wr_ack, q); end
        tick();
        vectors++; if (q !== 8'h6B) begin miscompares++; $display("FAIL rel_hold got=%h want=6b", q); end
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b1000; wdata = {8'h77, 8'h03, 8'h02, 8'h01};
        tick(); tick();
        vectors++; if (q !== 8'h77) begin miscompares++; $display("FAIL rmg_first got=%h want=77", q); end
        rst = 1'b0; wdata[3*W +: W] = 8'h88; tick();
        vectors++; if (q !== 8'h00 || grant !== 4'b0000 || wr_ack !== 1'b0) begin miscompares++; $display("FAIL rmg_reset got q=%h g=%b ack=%b want q=00 g=0000 ack=0", q, grant, wr_ack); end
        rst = 1'b1; req = 4'b1111; tick();
        vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL rmg_first_winner got=%b want=0001", grant); end
        req = '0; tick();
        vectors++; if (act_vec() !== exp_vec()) begin miscompares++; $display("FAIL rmg_model got=%h want=%h", act_vec(), exp_vec()); end
    endtask

    task automatic test_noise();
        logic [W-1:0] d;
        req = 4'b0001; tick();
        for (int i = 0; i < 3; i++) begin
            req[2] = ~req[2];
            d = W'($urandom);
            wdata = {W'($urandom), W'($urandom), W'($urandom), d};
            tick();
            vectors++; if (q !== d || grant !== 4'b0001) begin miscompares++; $display("FAIL noise got q=%h g=%b want q=%h g=0001", q, grant, d); end
        end
        req = '0; tick();
        vectors++; if (act_vec() !== exp_vec()) begin miscompares++; $display("FAIL noise_model got=%h want=%h", act_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) != 0);
            req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            wdata = {$urandom, $urandom};
            tick();
            vectors++; if (act_vec() !== exp_vec()) begin miscompares++; $display("FAIL random cyc=%0d got=%h want=%h", c, act_vec(), exp_vec()); end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_release();
        test_reset_mid_grant();
        test_noise();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
